bl_deser8_fsm: RTL and testbench
================================

# bl_deser8_fsm

Stream deserializer for the JPEG decode block-level datapath. It accepts one scalar token stream, collects 8 consecutive words into a row buffer, and presents the row as 8 parallel lane streams `s`..`z`. Each lane uses the standard `_e`/`_v`/`_b` stream protocol. The block feeds 8-lane lockstep consumers that require all lanes valid before firing. It is the scatter end of the 8-lane gather stage.

## Interface
Parameters:
- `W`, default 16: data width of every stream, in bits.

Ports:
- `clock`, input, 1 bit: single clock. All state changes on the rising edge.
- `reset`, input, 1 bit: synchronous reset, active-low. Sampled on the `clock` rising edge.
- `a_e`, input, 1 bit: end-of-stream flag on the input stream. Meaningful only when `a_v` = 1.
- `a_v`, input, 1 bit: input token valid.
- `a_b`, output, 1 bit: input back-pressure. When 1, the producer must hold its token.
- `a_d`, input, W bits: input data.
- `s_e` .. `z_e`, output, 1 bit each: lane end-of-stream flag. Lanes are s=0, t=1, ... z=7.
- `s_v` .. `z_v`, output, 1 bit each: lane token valid.
- `s_b` .. `z_b`, input, 1 bit each: lane back-pressure from the consumer.
- `s_d` .. `z_d`, output, W bits each: lane data.
- `statecase`, output, 2 bits: current FSM state, for debug and trace.

## Operation
- **Transfer rule.** A token transfers on a stream in any cycle where `_v` = 1 and `_b` = 0. A token with `_e` = 1 is an EOS token and carries no data.
- **State encoding.** FILL = 0, DRAIN = 1, EOS = 2.
- **FILL.**
  - `a_b` = 0.
  - Data token accepted: write `buf[idx]` = `a_d`, then increment `idx`.
  - If `idx` was 7: set all 8 lane `pend` flags, set `idx` = 0, go to DRAIN.
  - EOS token with `idx` = 0: set all `pend` flags with `eflag` = 1, go to EOS.
  - EOS token with `idx` > 0: zero `buf[idx..7]`, set all `pend` flags, set `eos_pending` = 1, set `idx` = 0, go to DRAIN. This pads the partial row.
- **DRAIN.**
  - `a_b` = 1.
  - Each lane k drives `_v` = `pend[k]`, `_e` = 0, `_d` = `buf[k]`.
  - `pend[k]` clears on lane k transfer. Lanes drain independently and in any order.
  - Exit when every `pend` is clear or clearing this cycle:
    - `eos_pending` = 1: set all `pend` flags with `eflag` = 1, clear `eos_pending`, go to EOS.
    - Otherwise: go to FILL.
- **EOS.**
  - `a_b` = 1.
  - Each lane k drives `_v` = `pend[k]`, `_e` = `pend[k]`, `_d` = 0.
  - `pend[k]` clears on transfer.
  - Exit to FILL when all `pend` flags are clear, then clear `eflag`.
  - The stream may carry further segments after EOS. The block does not terminate.
- **Input side.** In FILL, tokens are accepted regardless of lane back-pressure.
- **Data path.** Data passes through unmodified. No arithmetic. `idx` is 3 bits.
- **Reset.**
  - Asserted: `state` = FILL, `idx` = 0, all `pend` = 0, `eflag` = 0, `eos_pending` = 0, all `buf` = 0.
  - Any partially collected row or undelivered lane token is discarded.
  - Mid-operation reset behaves the same as power-on reset.

## Timing
- **Output reset values.**
  - While `reset` = 0 and for the first cycle after release: all lane `_v` = 0, `_e` = 0, `_d` = 0, and `statecase` = 0.
  - `a_b` = 1 while `reset` = 0. `a_b` = 0 from the first cycle after release.
- **Registered outputs.** Lane outputs come from registers only. There is no combinational path from `a_*` or `*_b` to any lane output.
- **Combinational path.** `a_b` is a combinational decode of `state`.
- **Row latency.** Last row word accepted in cycle N: all 8 lanes `_v` = 1 in cycle N+1.
- **Row period.** With no back-pressure, a row takes 8 FILL cycles plus 1 DRAIN cycle. FILL resumes in cycle N+2.
- **Drain timing.** The DRAIN→EOS and EOS→FILL transitions occur in the same cycle as the last lane transfer.
- **Simultaneous lane events.** Several lanes transferring in one cycle clear their `pend` flags together.
- **Held tokens.** A lane whose `_b` stays high holds its `_v` and `_d` stable indefinitely.

## Structure
- **Shared package** `bl_stream_pkg`:
  - `LANES` = 8.
  - State enum FILL/DRAIN/EOS with a 2-bit encoding.
  - Lane index type.
- **Sub-module** `bl_deser8_lane`: one instance per lane. Holds `pend`, `eflag` and `buf[k]`, has load/clear inputs, and drives `_e`/`_v`/`_d`. The top-level block holds `idx`, `eos_pending` and the FSM.

## Test plan
- **Basic row.** After reset, feed 8 data tokens `0x0001`..`0x0008`, with all lane `_b` = 0.
  - All 8 lanes `_v` = 1 in the cycle after the 8th token, with `s_d` = 1 .. `z_d` = 8.
  - `a_b` = 1 for exactly 1 cycle.
- **Staggered drain.** Full row loaded; `u_b` held 1 for 5 cycles, others 0.
  - Other lanes deliver once.
  - `u_v` stays 1 with stable data, then delivers.
  - `a_b` returns to 0 in the cycle after `u` transfers.
- **EOS at row boundary.** EOS token with `idx` = 0.
  - All lanes show `_e` = 1, `_v` = 1 for one cycle.
  - State goes EOS→FILL.
- **Partial row plus EOS.** 3 data tokens (`0xA`, `0xB`, `0xC`), then EOS.
  - Row `s`..`u` = `0xA`, `0xB`, `0xC`; `v`..`z` = 0.
  - The following cycle shows the EOS row.
  - The next segment's first token lands in `s`.
- **Reset mid-operation.** 5 tokens loaded, then `reset` = 0 for 1 cycle.
  - All lane `_v` = 0 and `statecase` = 0.
  - The next 8 tokens form a clean row starting at `s`.
- **Back-to-back throughput.** 4 rows streamed with no lane back-pressure.
  - 32 lane transfers per lane group, delivered in 36 cycles.

Source files
------------

// File: rtl/bl_stream_pkg.sv
// Shared types for the 8-lane stream gather/scatter stage.
package bl_stream_pkg;

  localparam int LANES = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EOS   = 2'd2
  } state_e;

  typedef logic [2:0] lane_idx_t;

endpackage

// File: rtl/bl_deser8_lane.sv
// One output lane of the deserializer: row word, pending flag and EOS flag.
module bl_deser8_lane #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         set_pend_i,
  input  logic         set_eflag_i,
  input  logic         clr_eflag_i,
  input  logic         b_i,
  output logic         e_o,
  output logic         v_o,
  output logic [W-1:0] d_o,
  output logic         pend_o,
  output logic         xfer_o
);

  logic [W-1:0] buf_q, buf_d;
  logic         pend_q, pend_d;
  logic         eflag_q, eflag_d;

  assign xfer_o = pend_q & ~b_i;

  always_comb begin
    buf_d   = buf_q;
    pend_d  = pend_q;
    eflag_d = eflag_q;
    if (wr_en_i) buf_d = wr_data_i;
    // A reload on the cycle of the last transfer must win over the clear.
    if (set_pend_i) begin
      pend_d  = 1'b1;
      eflag_d = set_eflag_i;
    end else begin
      if (xfer_o) pend_d = 1'b0;
      if (clr_eflag_i) eflag_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      buf_q   <= '0;
      pend_q  <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      eflag_q <= eflag_d;
    end
  end

  assign v_o    = pend_q;
  assign e_o    = pend_q & eflag_q;
  assign d_o    = eflag_q ? '0 : buf_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/bl_deser8_fsm.sv
// Scalar-to-8-lane stream deserializer: collects rows of 8 words, pads partial rows on EOS.
module bl_deser8_fsm
  import bl_stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a_e,
  input  logic         a_v,
  output logic         a_b,
  input  logic [W-1:0] a_d,
  output logic         s_e, t_e, u_e, v_e, w_e, x_e, y_e, z_e,
  output logic         s_v, t_v, u_v, v_v, w_v, x_v, y_v, z_v,
  input  logic         s_b, t_b, u_b, v_b, w_b, x_b, y_b, z_b,
  output logic [W-1:0] s_d, t_d, u_d, v_d, w_d, x_d, y_d, z_d,
  output logic [1:0]   statecase
);

  state_e    state_q, state_d;
  lane_idx_t idx_q, idx_d;
  logic      eos_pend_q, eos_pend_d;

  logic [LANES-1:0] wr_en, lane_b, lane_e, lane_v, lane_pend, lane_xfer;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     lane_d [LANES];
  logic             set_pend, set_eflag, clr_eflag, all_clear;

  assign lane_b    = {z_b, y_b, x_b, w_b, v_b, u_b, t_b, s_b};
  assign all_clear = &(~lane_pend | lane_xfer);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    eos_pend_d = eos_pend_q;
    wr_en      = '0;
    wr_data    = a_d;
    set_pend   = 1'b0;
    set_eflag  = 1'b0;
    clr_eflag  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (a_v) begin
          if (!a_e) begin
            wr_en[idx_q] = 1'b1;
            if (idx_q == 3'd7) begin
              set_pend = 1'b1;
              idx_d    = '0;
              state_d  = ST_DRAIN;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else if (idx_q == '0) begin
            set_pend  = 1'b1;
            set_eflag = 1'b1;
            state_d   = ST_EOS;
          end else begin
            // Pad the tail of the partial row with zeros before draining it.
            wr_data = '0;
            for (int k = 0; k < LANES; k++) begin
              if (k >= int'(idx_q)) wr_en[k] = 1'b1;
            end
            set_pend   = 1'b1;
            eos_pend_d = 1'b1;
            idx_d      = '0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (all_clear) begin
          if (eos_pend_q) begin
            set_pend   = 1'b1;
            set_eflag  = 1'b1;
            eos_pend_d = 1'b0;
            state_d    = ST_EOS;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_EOS: begin
        if (all_clear) begin
          clr_eflag = 1'b1;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_FILL;
      idx_q      <= '0;
      eos_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      eos_pend_q <= eos_pend_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bl_deser8_lane #(.W(W)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (wr_en[k]),
      .wr_data_i  (wr_data),
      .set_pend_i (set_pend),
      .set_eflag_i(set_eflag),
      .clr_eflag_i(clr_eflag),
      .b_i        (lane_b[k]),
      .e_o        (lane_e[k]),
      .v_o        (lane_v[k]),
      .d_o        (lane_d[k]),
      .pend_o     (lane_pend[k]),
      .xfer_o     (lane_xfer[k])
    );
  end

  assign a_b       = !reset || (state_q != ST_FILL);
  assign statecase = state_q;

  assign {z_e, y_e, x_e, w_e, v_e, u_e, t_e, s_e} = lane_e;
  assign {z_v, y_v, x_v, w_v, v_v, u_v, t_v, s_v} = lane_v;
  assign s_d = lane_d[0];
  assign t_d = lane_d[1];
  assign u_d = lane_d[2];
  assign v_d = lane_d[3];
  assign w_d = lane_d[4];
  assign x_d = lane_d[5];
  assign y_d = lane_d[6];
  assign z_d = lane_d[7];

endmodule

// File: tb/tb_bl_deser8_fsm.sv
// Self-checking bench for bl_deser8_fsm: directed scenarios plus a randomized scoreboard run.
module tb_bl_deser8_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_e = 1'b0, a_v = 1'b0, a_b;
  logic [15:0] a_d = '0;
  logic        s_e, t_e, u_e, v_e, w_e, x_e, y_e, z_e;
  logic        s_v, t_v, u_v, v_v, w_v, x_v, y_v, z_v;
  logic        s_b, t_b, u_b, v_b, w_b, x_b, y_b, z_b;
  logic [15:0] s_d, t_d, u_d, v_d, w_d, x_d, y_d, z_d;
  logic [1:0]  statecase;

  logic [7:0]  lb = '0;
  logic [7:0]  lv, le;
  logic [15:0] ld [8];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int xfers = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    xfers <= xfers + $countones(lv & ~lb);
  end

  assign {z_b, y_b, x_b, w_b, v_b, u_b, t_b, s_b} = lb;
  assign lv = {z_v, y_v, x_v, w_v, v_v, u_v, t_v, s_v};
  assign le = {z_e, y_e, x_e, w_e, v_e, u_e, t_e, s_e};
  assign ld[0] = s_d;
  assign ld[1] = t_d;
  assign ld[2] = u_d;
  assign ld[3] = v_d;
  assign ld[4] = w_d;
  assign ld[5] = x_d;
  assign ld[6] = y_d;
  assign ld[7] = z_d;

  bl_deser8_fsm #(.W(16)) dut (
    .clock(clock), .reset(reset),
    .a_e(a_e), .a_v(a_v), .a_b(a_b), .a_d(a_d),
    .s_e(s_e), .t_e(t_e), .u_e(u_e), .v_e(v_e), .w_e(w_e), .x_e(x_e), .y_e(y_e), .z_e(z_e),
    .s_v(s_v), .t_v(t_v), .u_v(u_v), .v_v(v_v), .w_v(w_v), .x_v(x_v), .y_v(y_v), .z_v(z_v),
    .s_b(s_b), .t_b(t_b), .u_b(u_b), .v_b(v_b), .w_b(w_b), .x_b(x_b), .y_b(y_b), .z_b(z_b),
    .s_d(s_d), .t_d(t_d), .u_d(u_d), .v_d(v_d), .w_d(w_d), .x_d(x_d), .y_d(y_d), .z_d(z_d),
    .statecase(statecase)
  );

  // Present one token and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic e, input logic [15:0] d);
    int n;
    a_v = 1'b1; a_e = e; a_d = d; n = 0;
    while (a_b !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL send_timeout a_b=%b after %0d cycles, required 0", a_b, n);
    end
    @(negedge clock);
    a_v = 1'b0; a_e = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b0; a_v = 1'b0; lb = '0;
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || le !== 8'h00 || statecase !== 2'd0 || a_b !== 1'b1 || ld[0] !== 16'h0 || ld[7] !== 16'h0)
      $display("FAIL reset_hold v=%h e=%h st=%0d a_b=%b s_d=%h z_d=%h, required v=00 e=00 st=0 a_b=1 d=0",
               lv, le, statecase, a_b, ld[0], ld[7]);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || statecase !== 2'd0 || a_b !== 1'b0)
      $display("FAIL reset_release v=%h st=%0d a_b=%b, required v=00 st=0 a_b=0", lv, statecase, a_b);
    else n_pass++;
  endtask

  task automatic test_basic_row;
    int c0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 16'(i + 1));
    n_total++;
    if (cyc - c0 !== 8) $display("FAIL basic_fill_cycles got %0d, required 8", cyc - c0);
    else n_pass++;
    n_total++;
    if (lv !== 8'hFF || le !== 8'h00 || a_b !== 1'b1 || statecase !== 2'd1)
      $display("FAIL basic_row_valid v=%h e=%h a_b=%b st=%0d, required v=ff e=00 a_b=1 st=1", lv, le, a_b, statecase);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (ld[k] !== 16'(k + 1)) $display("FAIL basic_row_data lane %0d got %h, required %h", k, ld[k], 16'(k + 1));
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || a_b !== 1'b0 || statecase !== 2'd0)
      $display("FAIL basic_row_after v=%h a_b=%b st=%0d, required v=00 a_b=0 st=0", lv, a_b, statecase);
    else n_pass++;
  endtask

  task automatic test_staggered;
    logic [15:0] row [8];
    for (int k = 0; k < 8; k++) row[k] = 16'($urandom);
    for (int k = 0; k < 8; k++) send(1'b0, row[k]);
    lb = 8'h04;
    n_total++;
    if (lv !== 8'hFF) $display("FAIL stagger_loaded v=%h, required ff", lv);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_total++;
      if (lv !== 8'h04 || ld[2] !== row[2] || a_b !== 1'b1 || statecase !== 2'd1)
        $display("FAIL stagger_hold cycle %0d v=%h u_d=%h a_b=%b st=%0d, required v=04 u_d=%h a_b=1 st=1",
                 i, lv, ld[2], a_b, statecase, row[2]);
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if (lv !== 8'h04 || ld[2] !== row[2]) $display("FAIL stagger_last v=%h u_d=%h, required v=04 u_d=%h", lv, ld[2], row[2]);
    else n_pass++;
    lb = 8'h00;
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || a_b !== 1'b0 || statecase !== 2'd0)
      $display("FAIL stagger_release v=%h a_b=%b st=%0d, required v=00 a_b=0 st=0", lv, a_b, statecase);
    else n_pass++;
  endtask

  task automatic test_eos_boundary;
    send(1'b1, 16'hDEAD);
    n_total++;
    if (lv !== 8'hFF || le !== 8'hFF || statecase !== 2'd2 || ld[0] !== 16'h0 || ld[7] !== 16'h0)
      $display("FAIL eos_row v=%h e=%h st=%0d s_d=%h z_d=%h, required v=ff e=ff st=2 d=0", lv, le, statecase, ld[0], ld[7]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || le !== 8'h00 || statecase !== 2'd0 || a_b !== 1'b0)
      $display("FAIL eos_exit v=%h e=%h st=%0d a_b=%b, required v=00 e=00 st=0 a_b=0", lv, le, statecase, a_b);
    else n_pass++;
  endtask

  task automatic test_partial_eos;
    logic [15:0] exp_row [8];
    logic [15:0] pat [3];
    pat[0] = 16'h000A; pat[1] = 16'h000B; pat[2] = 16'h000C;
    for (int k = 0; k < 8; k++) exp_row[k] = (k < 3) ? pat[k] : 16'h0;
    for (int k = 0; k < 3; k++) send(1'b0, pat[k]);
    send(1'b1, 16'hFFFF);
    n_total++;
    if (lv !== 8'hFF || le !== 8'h00 || statecase !== 2'd1)
      $display("FAIL partial_row v=%h e=%h st=%0d, required v=ff e=00 st=1", lv, le, statecase);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (ld[k] !== exp_row[k]) $display("FAIL partial_data lane %0d got %h, required %h", k, ld[k], exp_row[k]);
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if (lv !== 8'hFF || le !== 8'hFF || statecase !== 2'd2 || ld[1] !== 16'h0)
      $display("FAIL partial_eos v=%h e=%h st=%0d t_d=%h, required v=ff e=ff st=2 t_d=0", lv, le, statecase, ld[1]);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (statecase !== 2'd0 || a_b !== 1'b0) $display("FAIL partial_exit st=%0d a_b=%b, required st=0 a_b=0", statecase, a_b);
    else n_pass++;
    for (int k = 0; k < 8; k++) send(1'b0, 16'h5500 + 16'(k));
    n_total++;
    if (lv !== 8'hFF || ld[0] !== 16'h5500 || ld[7] !== 16'h5507)
      $display("FAIL next_segment v=%h s_d=%h z_d=%h, required v=ff s_d=5500 z_d=5507", lv, ld[0], ld[7]);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 5; k++) send(1'b0, 16'h0F00 + 16'(k));
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (lv !== 8'h00 || statecase !== 2'd0) $display("FAIL midreset v=%h st=%0d, required v=00 st=0", lv, statecase);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 8; k++) send(1'b0, 16'h0A00 + 16'(k));
    n_total++;
    if (lv !== 8'hFF || ld[0] !== 16'h0A00 || ld[4] !== 16'h0A04 || ld[7] !== 16'h0A07)
      $display("FAIL midreset_row v=%h s_d=%h w_d=%h z_d=%h, required v=ff s_d=0a00 w_d=0a04 z_d=0a07",
               lv, ld[0], ld[4], ld[7]);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int c0, x0;
    lb = 8'h00;
    c0 = cyc; x0 = xfers;
    for (int i = 0; i < 32; i++) send(1'b0, 16'($urandom));
    @(negedge clock);
    n_total++;
    if (cyc - c0 !== 36 || xfers - x0 !== 32 || statecase !== 2'd0 || a_b !== 1'b0)
      $display("FAIL back_to_back cycles=%0d xfers=%0d st=%0d a_b=%b, required cycles=36 xfers=32 st=0 a_b=0",
               cyc - c0, xfers - x0, statecase, a_b);
    else n_pass++;
  endtask

  // Scoreboard: expected per-lane token sequences built from row/EOS rules. Bit 16 = EOS flag.
  task automatic test_random;
    logic [16:0] expq [8][$];
    logic [15:0] row [$];
    logic [16:0] got, want;
    logic        fresh;
    fresh = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      if (c < 1450) begin
        if (fresh || !a_v) begin
          a_v = ($urandom_range(0, 9) < 8);
          a_e = ($urandom_range(0, 9) == 0);
          a_d = 16'($urandom);
        end
        lb = 8'($urandom) & 8'($urandom);
      end else begin
        a_v = 1'b0; a_e = 1'b0; lb = 8'h00;
      end
      for (int k = 0; k < 8; k++) begin
        if (lv[k] === 1'b1 && lb[k] === 1'b0) begin
          got = {le[k], ld[k]};
          n_total++;
          if (expq[k].size() == 0) begin
            $display("FAIL rand_unexpected lane %0d got %h, required no token", k, got);
          end else begin
            want = expq[k].pop_front();
            if (got !== want) $display("FAIL rand_lane lane %0d got %h, required %h", k, got, want);
            else n_pass++;
          end
        end
      end
      fresh = 1'b0;
      if (a_v && a_b === 1'b0) begin
        fresh = 1'b1;
        if (!a_e) begin
          row.push_back(a_d);
          if (row.size() == 8) begin
            for (int k = 0; k < 8; k++) expq[k].push_back({1'b0, row[k]});
            row.delete();
          end
        end else begin
          if (row.size() > 0) begin
            while (row.size() < 8) row.push_back(16'h0);
            for (int k = 0; k < 8; k++) expq[k].push_back({1'b0, row[k]});
            row.delete();
          end
          for (int k = 0; k < 8; k++) expq[k].push_back({1'b1, 16'h0});
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (expq[k].size() != 0) $display("FAIL rand_leftover lane %0d has %0d undelivered, required 0", k, expq[k].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_basic_row;
    test_staggered;
    test_eos_boundary;
    test_partial_eos;
    test_reset_mid;
    test_back_to_back;
    test_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
